// File: rtl/lcd12864_bus_monitor_if.sv
// rtl/lcd12864_bus_monitor_if.sv - ST7920 8-bit parallel write bus bundle
// Signals:
//   lcd_dat  8  data bus
//   lcd_rs   1  0 = command, 1 = data
//   lcd_rw   1  0 = write, 1 = read
//   lcd_en   1  strobe, byte taken on falling edge
// Modports: master drives the bus (display driver), slave observes it (display side).
interface lcd12864_bus_monitor_if;
  logic [7:0] lcd_dat;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;

  modport master (output lcd_dat, output lcd_rs, output lcd_rw, output lcd_en);
  modport slave  (input  lcd_dat, input  lcd_rs, input  lcd_rw, input  lcd_en);
endinterface

// File: rtl/lcd12864_bus_monitor.sv
// rtl/lcd12864_bus_monitor.sv - ST7920 write-bus decoder with 64-byte DDRAM text image
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   bus (slave)           lcd_dat/lcd_rs/lcd_rw/lcd_en, asynchronous to clk
//   wr_valid/wr_rs/wr_byte  one-cycle report of each accepted write strobe
//   busy                  high while the clear fill runs
//   display_on, incr_mode, ac  decoded display state and address counter
//   rd_addr/rd_data       image read port, 1-cycle registered latency
//   err_clr, err_glitch, err_overrun  sticky error flags and their clear
module lcd12864_bus_monitor #(
  parameter int         SYNC_STAGES = 2,
  parameter int         MIN_EN_HIGH = 4,
  parameter logic [7:0] CLEAR_CHAR  = 8'h20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  lcd12864_bus_monitor_if.slave   bus,
  output logic                    wr_valid,
  output logic                    wr_rs,
  output logic [7:0]              wr_byte,
  output logic                    busy,
  output logic                    display_on,
  output logic                    incr_mode,
  output logic [5:0]              ac,
  input  logic [5:0]              rd_addr,
  output logic [7:0]              rd_data,
  input  logic                    err_clr,
  output logic                    err_glitch,
  output logic                    err_overrun
);

  localparam int             WW    = $clog2(MIN_EN_HIGH + 1);
  localparam logic [WW-1:0]  MIN_W = MIN_EN_HIGH[WW-1:0];
  // Synchronizer word is {en, rw, rs, dat}. The en bit resets high so that a
  // strobe already in progress at reset release looks like "still high" and is
  // discarded by the capture FSM instead of appearing as a fresh rising edge.
  localparam logic [10:0]    SYNC_RST = 11'h400;

  typedef enum logic [1:0] {CAP_WAIT_LOW, CAP_EN_LOW, CAP_EN_HIGH} cap_state_t;
  typedef enum logic       {CLR_IDLE, CLR_FILL} clr_state_t;

  logic [10:0]   sync_q [SYNC_STAGES];
  logic          en_s, rw_s, rs_s;
  logic [7:0]    dat_s;

  cap_state_t    cap_state, cap_next;
  logic          cap_latch, cap_fall;
  logic [WW-1:0] width;
  logic          wide_enough;
  logic [7:0]    lat_dat;
  logic          lat_rs, lat_rw;
  logic          strobe_pend;

  clr_state_t    clr_state, clr_next;
  logic [5:0]    clr_idx;
  logic          clear_start;
  logic          decode_ok;

  logic          mem_we;
  logic [5:0]    mem_waddr;
  logic [7:0]    mem_wdata;
  logic [7:0]    image [64];

  // ---------------- input synchronizer ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= {bus.lcd_en, bus.lcd_rw, bus.lcd_rs, bus.lcd_dat};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign en_s  = sync_q[SYNC_STAGES-1][10];
  assign rw_s  = sync_q[SYNC_STAGES-1][9];
  assign rs_s  = sync_q[SYNC_STAGES-1][8];
  assign dat_s = sync_q[SYNC_STAGES-1][7:0];

  // ---------------- strobe capture FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cap_state <= CAP_WAIT_LOW;
    else        cap_state <= cap_next;
  end

  always_comb begin
    cap_next  = cap_state;
    cap_latch = 1'b0;
    cap_fall  = 1'b0;
    case (cap_state)
      CAP_WAIT_LOW: if (!en_s) cap_next = CAP_EN_LOW;
      CAP_EN_LOW: begin
        if (en_s) begin
          cap_next  = CAP_EN_HIGH;
          cap_latch = 1'b1;
        end
      end
      CAP_EN_HIGH: begin
        if (en_s) begin
          cap_latch = 1'b1;
        end else begin
          cap_next = CAP_EN_LOW;
          cap_fall = 1'b1;
        end
      end
      default: cap_next = CAP_WAIT_LOW;
    endcase
  end

  assign wide_enough = (width >= MIN_W);

  // Width saturates at MIN_EN_HIGH: only "long enough or not" matters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width       <= '0;
      lat_dat     <= 8'h00;
      lat_rs      <= 1'b0;
      lat_rw      <= 1'b0;
      strobe_pend <= 1'b0;
    end else begin
      if (cap_state == CAP_EN_LOW && en_s)
        width <= {{(WW-1){1'b0}}, 1'b1};
      else if (cap_state == CAP_EN_HIGH && en_s && width < MIN_W)
        width <= width + 1'b1;
      if (cap_latch) begin
        lat_dat <= dat_s;
        lat_rs  <= rs_s;
        lat_rw  <= rw_s;
      end
      strobe_pend <= cap_fall && wide_enough && !lat_rw;
    end
  end

  // ---------------- clear FSM ----------------
  assign busy        = (clr_state == CLR_FILL);
  assign decode_ok   = strobe_pend && !busy;
  assign clear_start = decode_ok && !lat_rs && (lat_dat == 8'h01);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_state <= CLR_FILL;
      clr_idx   <= 6'd0;
    end else begin
      clr_state <= clr_next;
      clr_idx   <= busy ? clr_idx + 6'd1 : 6'd0;
    end
  end

  always_comb begin
    clr_next = clr_state;
    case (clr_state)
      CLR_IDLE: if (clear_start) clr_next = CLR_FILL;
      CLR_FILL: if (clr_idx == 6'd63) clr_next = CLR_IDLE;
      default:  clr_next = CLR_IDLE;
    endcase
  end

  // ---------------- image RAM ----------------
  // Fill and data writes never collide: data writes are dropped while busy.
  always_comb begin
    mem_we    = busy || (decode_ok && lat_rs);
    mem_waddr = busy ? clr_idx : ac;
    mem_wdata = busy ? CLEAR_CHAR : lat_dat;
  end

  always_ff @(posedge clk) begin
    if (mem_we) image[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= 8'h00;
    else        rd_data <= image[rd_addr];
  end

  // ---------------- decode and status ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_valid    <= 1'b0;
      wr_rs       <= 1'b0;
      wr_byte     <= 8'h00;
      ac          <= 6'd0;
      incr_mode   <= 1'b1;
      display_on  <= 1'b0;
      err_glitch  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      wr_valid <= strobe_pend;
      if (strobe_pend) begin
        wr_rs   <= lat_rs;
        wr_byte <= lat_dat;
      end
      if (decode_ok) begin
        if (lat_rs) begin
          ac <= incr_mode ? ac + 6'd1 : ac - 6'd1;
        end else if (lat_dat == 8'h01) begin
          ac        <= 6'd0;
          incr_mode <= 1'b1;
        end else if (lat_dat[7]) begin
          ac <= {lat_dat[4:0], 1'b0};
        end else if (lat_dat[7:1] == 7'h01) begin
          ac <= 6'd0;
        end else if (lat_dat[7:2] == 6'h01) begin
          incr_mode <= lat_dat[1];
        end else if (lat_dat[7:3] == 5'h01) begin
          display_on <= lat_dat[2];
        end
      end
      // A new event wins over err_clr in the same cycle.
      if (cap_fall && !wide_enough) err_glitch <= 1'b1;
      else if (err_clr)             err_glitch <= 1'b0;
      if (strobe_pend && busy)      err_overrun <= 1'b1;
      else if (err_clr)             err_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd12864_bus_monitor.sv
// tb/tb_lcd12864_bus_monitor.sv - directed self-checking bench for lcd12864_bus_monitor
module tb_lcd12864_bus_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid, wr_rs, busy, display_on, incr_mode;
  logic [7:0] wr_byte, rd_data;
  logic [5:0] ac;
  logic [5:0] rd_addr = 6'd0;
  logic       err_clr = 1'b0;
  logic       err_glitch, err_overrun;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  logic [7:0] last_byte = 8'h00;
  logic       last_rs = 1'b0;

  lcd12864_bus_monitor_if bus ();

  lcd12864_bus_monitor #(
    .SYNC_STAGES (2),
    .MIN_EN_HIGH (4),
    .CLEAR_CHAR  (8'h20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .wr_valid    (wr_valid),
    .wr_rs       (wr_rs),
    .wr_byte     (wr_byte),
    .busy        (busy),
    .display_on  (display_on),
    .incr_mode   (incr_mode),
    .ac          (ac),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .err_clr     (err_clr),
    .err_glitch  (err_glitch),
    .err_overrun (err_overrun)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && wr_valid) begin
      wr_count  = wr_count + 1;
      last_byte = wr_byte;
      last_rs   = wr_rs;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one strobe, en high for hi cycles; lat = negedges from en low to wr_valid (-1 if none).
  task automatic lcd_write(input logic rs, input logic [7:0] d, input int hi,
                           input logic rw, output int lat);
    @(negedge clk);
    bus.lcd_dat = d;
    bus.lcd_rs  = rs;
    bus.lcd_rw  = rw;
    @(negedge clk);
    bus.lcd_en = 1'b1;
    repeat (hi) @(negedge clk);
    bus.lcd_en = 1'b0;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (wr_valid && lat < 0) lat = i;
    end
  endtask

  task automatic wr(input logic rs, input logic [7:0] d);
    int lat;
    lcd_write(rs, d, 8, 1'b0, lat);
  endtask

  task automatic read_img(input logic [5:0] a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", busy, 1'b0);
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int lat, cnt, base;

    bus.lcd_dat = 8'h00;
    bus.lcd_rs  = 1'b0;
    bus.lcd_rw  = 1'b0;
    bus.lcd_en  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_ac", ac, 6'd0);
    check("rst_incr", incr_mode, 1'b1);
    check("rst_disp", display_on, 1'b0);
    check("rst_errs", {err_glitch, err_overrun}, 2'b00);
    check("rst_rd_data", rd_data, 8'h00);

    // 1. Auto-clear after reset release
    rst_n = 1'b1;
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check("autoclear_len", cnt, 64);
    for (int a = 0; a < 64; a++) begin
      read_img(a[5:0], d);
      check($sformatf("clr_img%0d", a), d, 8'h20);
    end

    // 2. Init sequence and "STA"
    base = wr_count;
    lcd_write(1'b0, 8'h30, 8, 1'b0, lat);
    check("latency", lat, 4);
    check("pulse_width", wr_count - base, 1);
    check("wr_rs_cmd", last_rs, 1'b0);
    check("wr_byte_cmd", last_byte, 8'h30);
    wr(1'b0, 8'h0C);
    wr(1'b0, 8'h06);
    wr(1'b0, 8'h01);
    wait_idle();
    wr(1'b1, "S");
    wr(1'b1, "T");
    wr(1'b1, "A");
    check("disp_on", display_on, 1'b1);
    check("incr_on", incr_mode, 1'b1);
    check("ac_sta", ac, 6'd3);
    check("wr_count_init", wr_count - base, 7);
    read_img(6'd0, d); check("img0_S", d, "S");
    read_img(6'd1, d); check("img1_T", d, "T");
    read_img(6'd2, d); check("img2_A", d, "A");
    read_img(6'd3, d); check("img3_blank", d, 8'h20);

    // 3. Set-address and wrap 63 -> 0
    wr(1'b0, 8'h90);
    check("ac_90", ac, 6'd32);
    wr(1'b1, "P");
    check("ac_33", ac, 6'd33);
    read_img(6'd32, d); check("img32_P", d, "P");
    wr(1'b0, 8'h9F);
    check("ac_9f", ac, 6'd62);
    wr(1'b1, "1");
    wr(1'b1, "2");
    wr(1'b1, "3");
    check("ac_wrap", ac, 6'd1);
    check("last_data_byte", last_byte, "3");
    check("last_data_rs", last_rs, 1'b1);
    read_img(6'd62, d); check("img62", d, "1");
    read_img(6'd63, d); check("img63", d, "2");
    read_img(6'd0, d);  check("img0_3", d, "3");

    // 4. Glitch rejection and err_clr
    base = wr_count;
    lcd_write(1'b1, "Z", 2, 1'b0, lat);
    check("glitch_no_wr", wr_count - base, 0);
    check("glitch_flag", err_glitch, 1'b1);
    check("glitch_ac", ac, 6'd1);
    pulse_err_clr();
    @(negedge clk);
    check("glitch_clr", err_glitch, 1'b0);
    lcd_write(1'b1, "Y", 4, 1'b0, lat);
    check("min_width_ok", lat, 4);
    check("min_width_ac", ac, 6'd2);

    // 5. Write during clear is dropped
    wr(1'b0, 8'h01);
    repeat (2) @(negedge clk);
    check("busy_after_clr", busy, 1'b1);
    base = wr_count;
    wr(1'b1, "X");
    check("overrun_wr", wr_count - base, 1);
    check("overrun_flag", err_overrun, 1'b1);
    wait_idle();
    check("overrun_ac", ac, 6'd0);
    read_img(6'd0, d); check("overrun_img0", d, 8'h20);
    read_img(6'd1, d); check("overrun_img1", d, 8'h20);
    pulse_err_clr();
    @(negedge clk);
    check("overrun_clr", err_overrun, 1'b0);

    // 6. Decrement mode wrap 0 -> 63, rw=1 ignored
    wr(1'b0, 8'h04);
    check("incr_off", incr_mode, 1'b0);
    wr(1'b0, 8'h80);
    check("ac_80", ac, 6'd0);
    wr(1'b1, "A");
    check("ac_dec_wrap", ac, 6'd63);
    wr(1'b1, "B");
    check("ac_62", ac, 6'd62);
    read_img(6'd0, d);  check("img0_A", d, "A");
    read_img(6'd63, d); check("img63_B", d, "B");
    base = wr_count;
    lcd_write(1'b1, "Q", 8, 1'b1, lat);
    check("rw_ignored", wr_count - base, 0);
    check("rw_ac", ac, 6'd62);

    // Reset with a strobe held high: strobe discarded, auto-clear restarts
    @(negedge clk);
    bus.lcd_dat = 8'h55;
    bus.lcd_rs  = 1'b1;
    bus.lcd_rw  = 1'b0;
    bus.lcd_en  = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst2_busy", busy, 1'b1);
    base = wr_count;
    repeat (6) @(negedge clk);
    bus.lcd_en = 1'b0;
    repeat (8) @(negedge clk);
    check("rst2_no_wr", wr_count - base, 0);
    check("rst2_ac", ac, 6'd0);
    wait_idle();
    read_img(6'd0, d); check("rst2_img0", d, 8'h20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
